seq_div: RTL

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div_pkg.sv | 38 +++
 rtl/seq_div_div_step.sv | 26 ++
 rtl/seq_div.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential 32-bit divider: FSM encoding,
// iteration count, result field layout and sign helpers.
package seq_div_pkg;

  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  // F = {quotient, remainder}
  localparam int Q_MSB = 2 * DATA_W - 1;
  localparam int Q_LSB = DATA_W;
  localparam int R_MSB = DATA_W - 1;
  localparam int R_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic            is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // Quotient is negated when operand signs differ; remainder follows the dividend.
  function automatic logic [2*DATA_W-1:0] pack_result(input logic [DATA_W-1:0] q,
                                                      input logic [DATA_W-1:0] r,
                                                      input logic              neg_q,
                                                      input logic              neg_r);
    logic [2*DATA_W-1:0] f;
    f = '0;
    f[Q_MSB:Q_LSB] = neg_q ? (~q + 1'b1) : q;
    f[R_MSB:R_LSB] = neg_r ? (~r + 1'b1) : r;
    return f;
  endfunction

endpackage

// File: rtl/seq_div_div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div_step
  import seq_div_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            borrow;

  // The partial remainder stays below the divisor, so the shifted value never
  // exceeds twice the divisor and the borrow bit is an exact compare.
  assign shifted = {rem_in, quo_in[DATA_W-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign borrow  = diff[DATA_W];

  assign rem_out = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_out = {quo_in[DATA_W-2:0], ~borrow};

endmodule

// File: rtl/seq_div.sv
// Sequential 32-cycle signed/unsigned divider with flush support.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when B==0 or |A|<|B|.
module seq_div
  import seq_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sign,
  input  logic                int_flush,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic                sourceData,
  output logic [2*DATA_W-1:0] F,
  output logic                hasData,
  output logic                dataOK
);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rem_q;
  logic [DATA_W-1:0]  quo_q;
  logic [DATA_W-1:0]  div_q;
  logic               neg_q;
  logic               neg_r;

  logic [DATA_W-1:0]  a_mag;
  logic [DATA_W-1:0]  b_mag;
  logic [DATA_W-1:0]  early_q;
  logic [DATA_W-1:0]  step_rem;
  logic [DATA_W-1:0]  step_quo;
  logic               accept;
  logic               early_out;
  logic               last_step;

  assign a_mag     = magnitude(A, sign);
  assign b_mag     = magnitude(B, sign);
  assign accept    = (state == IDLE) && sourceData && !int_flush;
  assign last_step = (state == BUSY) && (cnt == CNT_W'(DIV_CYCLES - 1));

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (b_mag == '0) || (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  // Divide-by-zero yields an all-ones quotient; otherwise |A|<|B| gives zero.
  assign early_q = (b_mag == '0) ? '1 : '0;

  div_step u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = early_out ? DONE : BUSY;
      BUSY:    if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (int_flush) next_state = IDLE;
  end

  // Operand/working registers are reset along with F so a reset mid-operation
  // leaves no stale state that could leak into a later result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      F     <= '0;
    end else if (accept) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= a_mag;
      div_q <= b_mag;
      neg_q <= sign && (A[DATA_W-1] ^ B[DATA_W-1]);
      neg_r <= sign && A[DATA_W-1];
      if (early_out)
        F <= pack_result(early_q, a_mag, sign && (A[DATA_W-1] ^ B[DATA_W-1]),
                         sign && A[DATA_W-1]);
    end else if (state == BUSY && !int_flush) begin
      cnt   <= cnt + 1'b1;
      rem_q <= step_rem;
      quo_q <= step_quo;
      // F is loaded on entry to DONE so it is already valid while dataOK is high.
      if (last_step) F <= pack_result(step_quo, step_rem, neg_q, neg_r);
    end
  end

  assign hasData = rst_n && ((state != IDLE) || accept);
  assign dataOK  = rst_n && (state == DONE);

endmodule
